display_arbiter: RTL and testbench

Shares the single seven-segment output driver between `NUM_REQ` independent producers, such as the ALU result path and the keypad echo path. Each producer presents a value over a valid/ready handshake. The block picks one producer by round-robin, captures its value, and holds it on the driver-facing valid/ready interface until the driver accepts it. An optional refresh feature re-sends the last displayed value after a period of inactivity.

---
 rtl/display_arbiter.sv | 156 +++++++++++++++
 tb/tb_display_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin share of the seven-segment driver; optional idle refresh under `DISPLAY_ARB_REFRESH_EN
module display_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_REQ        = 2,
  parameter int REFRESH_CYCLES = 1024,
  parameter int ID_W           = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]            i_req_error,
  input  logic [NUM_REQ-1:0]            i_req_is_neg,
  output logic [DATA_WIDTH-1:0]         o_drv_data,
  output logic                          o_drv_error,
  output logic                          o_drv_is_neg,
  output logic                          o_drv_valid,
  input  logic                          i_drv_ready,
  output logic [ID_W-1:0]               o_grant_id
);

  // Reject illegal parameterisations at elaboration
  if ((DATA_WIDTH % 4) != 0 || NUM_REQ < 2 || REFRESH_CYCLES < 2) begin : g_param_check
    $error("display_arbiter: illegal parameter value");
  end

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [ID_W:0]   NREQ    = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t                  state;
  logic [ID_W-1:0]         rr_ptr;
  logic [ID_W-1:0]         next_ptr;
  logic [2*NUM_REQ-1:0]    valid_dbl;
  logic [2*NUM_REQ-1:0]    valid_rot;
  logic                    win_found;
  logic [ID_W-1:0]         win_idx;
  logic [ID_W:0]           win_sum;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    win_error;
  logic                    win_neg;

`ifdef DISPLAY_ARB_REFRESH_EN
  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);
  logic [CNT_W-1:0] idle_cnt;
  logic             have_last;
  logic             is_refresh;
`endif

  // Rotating the doubled valid vector puts rr_ptr at bit 0, so the first set bit is the winner
  assign valid_dbl = {i_req_valid, i_req_valid};
  assign valid_rot = valid_dbl >> rr_ptr;

  // Round-robin search: lowest offset from rr_ptr wins (loop runs downward so the lowest overrides)
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_sum   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid_rot[i]) begin
        win_sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
        if (win_sum >= NREQ) win_sum = win_sum - NREQ;
        win_idx   = win_sum[ID_W-1:0];
        win_found = 1'b1;
      end
    end
  end

  // Select the winning requester's payload
  always_comb begin
    win_data  = '0;
    win_error = 1'b0;
    win_neg   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == ID_W'(k)) begin
        win_data  = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
        win_error = i_req_error[k];
        win_neg   = i_req_is_neg[k];
      end
    end
  end

  // Ready pulses only toward the winner while idle and out of reset
  always_comb begin
    o_req_ready = '0;
    if (rst_n && state == IDLE && win_found) o_req_ready = NUM_REQ'(1) << win_idx;
  end

  // Pointer moves one past the requester just served
  always_comb begin
    next_ptr = (o_grant_id == LAST_ID) ? '0 : o_grant_id + 1'b1;
  end

  // Arbitration FSM with registered driver-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      o_drv_valid  <= 1'b0;
      o_drv_data   <= '0;
      o_drv_error  <= 1'b0;
      o_drv_is_neg <= 1'b0;
      o_grant_id   <= '0;
`ifdef DISPLAY_ARB_REFRESH_EN
      idle_cnt     <= '0;
      have_last    <= 1'b0;
      is_refresh   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            o_drv_data   <= win_data;
            o_drv_error  <= win_error;
            o_drv_is_neg <= win_neg;
            o_grant_id   <= win_idx;
            o_drv_valid  <= 1'b1;
            state        <= SEND;
`ifdef DISPLAY_ARB_REFRESH_EN
            idle_cnt     <= '0;
            is_refresh   <= 1'b0;
`endif
          end
`ifdef DISPLAY_ARB_REFRESH_EN
          else if (have_last && idle_cnt == CNT_LAST) begin
            // Re-present the held value; payload and grant are left untouched
            o_drv_valid <= 1'b1;
            state       <= SEND;
            idle_cnt    <= '0;
            is_refresh  <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        SEND: begin
          if (i_drv_ready) begin
            o_drv_valid <= 1'b0;
            state       <= IDLE;
`ifdef DISPLAY_ARB_REFRESH_EN
            have_last   <= 1'b1;
            if (!is_refresh) rr_ptr <= next_ptr;
`else
            rr_ptr      <= next_ptr;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - self-checking bench for display_arbiter against a behavioural model
module tb_display_arbiter;

  localparam int DW = 16;
  localparam int N  = 2;
  localparam int RC = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  i_req_valid;
  logic [N-1:0]  o_req_ready;
  logic [N*DW-1:0] i_req_data;
  logic [N-1:0]  i_req_error;
  logic [N-1:0]  i_req_is_neg;
  logic [DW-1:0] o_drv_data;
  logic          o_drv_error;
  logic          o_drv_is_neg;
  logic          o_drv_valid;
  logic          i_drv_ready;
  logic [0:0]    o_grant_id;

  display_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .REFRESH_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_data(i_req_data), .i_req_error(i_req_error), .i_req_is_neg(i_req_is_neg),
    .o_drv_data(o_drv_data), .o_drv_error(o_drv_error), .o_drv_is_neg(o_drv_is_neg),
    .o_drv_valid(o_drv_valid), .i_drv_ready(i_drv_ready), .o_grant_id(o_grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: one pending transfer slot and a round-robin pointer
  bit          m_busy;
  int          m_ptr;
  logic [15:0] m_data;
  bit          m_err, m_neg;
  int          m_gid;
  bit          m_refresh;
  int          m_cnt;
  bit          m_have_last;

  logic [15:0] seen [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_ptr = 0; m_data = 0; m_err = 0; m_neg = 0; m_gid = 0;
    m_refresh = 0; m_cnt = 0; m_have_last = 0;
  endfunction

  function automatic int winner();
    for (int o = 0; o < N; o++)
      if (i_req_valid[(m_ptr + o) % N]) return (m_ptr + o) % N;
    return -1;
  endfunction

  task automatic check_all();
    int w;
    int exp_ready;
    w = m_busy ? -1 : winner();
    exp_ready = (w < 0 || !rst_n) ? 0 : (1 << w);
    chk("req_ready", 32'(o_req_ready), exp_ready);
    chk("drv_valid", 32'(o_drv_valid), 32'(m_busy));
    chk("drv_data", 32'(o_drv_data), 32'(m_data));
    chk("drv_error", 32'(o_drv_error), 32'(m_err));
    chk("drv_neg", 32'(o_drv_is_neg), 32'(m_neg));
    chk("grant_id", 32'(o_grant_id), m_gid);
  endtask

  task automatic model_edge();
    int w;
    if (!rst_n) begin
      model_reset();
    end else if (m_busy) begin
      if (i_drv_ready) begin
        m_busy = 0;
        m_have_last = 1;
        if (!m_refresh) m_ptr = (m_gid + 1) % N;
      end
    end else begin
      w = winner();
      if (w >= 0) begin
        m_busy = 1; m_data = i_req_data[w*DW +: DW]; m_err = i_req_error[w];
        m_neg = i_req_is_neg[w]; m_gid = w; m_refresh = 0; m_cnt = 0;
      end else begin
`ifdef DISPLAY_ARB_REFRESH_EN
        if (m_have_last && m_cnt == RC - 1) begin
          m_busy = 1; m_refresh = 1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
`endif
      end
    end
  endtask

  // One clock: drive at the falling edge, check, advance model across the rising edge
  task automatic cyc(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1,
                     input logic [1:0] e, input logic [1:0] n, input logic r);
    i_req_valid  = v;
    i_req_data   = {d1, d0};
    i_req_error  = e;
    i_req_is_neg = n;
    i_drv_ready  = r;
    #1;
    check_all();
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2'b11, 16'h1111, 16'h2222, 2'b00, 2'b00, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    i_req_valid = '0; i_req_data = '0; i_req_error = '0; i_req_is_neg = '0; i_drv_ready = 1'b0;
    @(negedge clk);

    // Reset state, with requests pending but ready held low
    cyc(2'b11, 16'h1111, 16'h2222, 2'b00, 2'b00, 1'b0);
    chk("reset_valid", 32'(o_drv_valid), 0);
    chk("reset_data", 32'(o_drv_data), 0);
    chk("reset_grant", 32'(o_grant_id), 0);
    rst_n = 1'b1;

    // Single transfer from requester 0
    cyc(2'b01, 16'h1234, 16'h0000, 2'b00, 2'b01, 1'b1);
    chk("tp1_valid", 32'(o_drv_valid), 1);
    chk("tp1_data", 32'(o_drv_data), 32'h1234);
    chk("tp1_neg", 32'(o_drv_is_neg), 1);
    chk("tp1_grant", 32'(o_grant_id), 0);
    cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
    chk("tp1_idle", 32'(o_drv_valid), 0);

    // Both requesters continuously valid: alternating service
    do_reset();
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      cyc(2'b11, 16'h0001, 16'h0002, 2'b00, 2'b00, 1'b1);
      if (o_drv_valid) seen.push_back(o_drv_data);
    end
    chk("rr_count", seen.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen.size()) chk("rr_order", 32'(seen[i]), (i % 2 == 0) ? 32'h0001 : 32'h0002);

    // Driver stall with requester 1 waiting
    cyc(2'b01, 16'hAAAA, 16'hBBBB, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(2'b10, 16'h0000, 16'hBBBB, 2'b00, 2'b00, 1'b0);
      chk("stall_data", 32'(o_drv_data), 32'hAAAA);
    end
    cyc(2'b10, 16'h0000, 16'hBBBB, 2'b00, 2'b00, 1'b1);
    cyc(2'b10, 16'h0000, 16'hBBBB, 2'b00, 2'b00, 1'b1);
    chk("stall_next_grant", 32'(o_grant_id), 1);
    chk("stall_next_data", 32'(o_drv_data), 32'hBBBB);
    cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);

    // Error flag passes through unchanged
    cyc(2'b10, 16'h0000, 16'hFFFF, 2'b10, 2'b00, 1'b0);
    chk("err_flag", 32'(o_drv_error), 1);
    chk("err_data", 32'(o_drv_data), 32'hFFFF);
    cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);

    // Reset while a transfer is pending
    cyc(2'b10, 16'h0000, 16'h5555, 2'b00, 2'b10, 1'b0);
    chk("pre_rst_valid", 32'(o_drv_valid), 1);
    do_reset();
    chk("rst_send_valid", 32'(o_drv_valid), 0);
    chk("rst_send_data", 32'(o_drv_data), 0);
    chk("rst_send_neg", 32'(o_drv_is_neg), 0);
    cyc(2'b11, 16'h0101, 16'h0202, 2'b00, 2'b00, 1'b1);
    chk("rst_send_grant", 32'(o_grant_id), 0);
    cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);

    // Idle refresh after one transfer
    do_reset();
    cyc(2'b01, 16'h00AB, 16'h0000, 2'b00, 2'b00, 1'b1);
    cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
    for (int i = 0; i < 16; i++) cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
`ifdef DISPLAY_ARB_REFRESH_EN
    chk("refresh_valid", 32'(o_drv_valid), 1);
    chk("refresh_data", 32'(o_drv_data), 32'h00AB);
`else
    chk("no_refresh_valid", 32'(o_drv_valid), 0);
`endif
    cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);

    // A request on the last idle cycle wins over the refresh
    for (int i = 0; i < 15; i++) cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);
    cyc(2'b10, 16'h0000, 16'h0777, 2'b00, 2'b00, 1'b0);
    chk("preempt_data", 32'(o_drv_data), 32'h0777);
    chk("preempt_grant", 32'(o_grant_id), 1);
    cyc(2'b00, 16'h0000, 16'h0000, 2'b00, 2'b00, 1'b1);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
      cyc(2'($urandom), 16'($urandom), 16'($urandom), 2'($urandom), 2'($urandom),
          ($urandom_range(0, 9) < 7));
      rst_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
